// File: rtl/dcache_direct.sv
// rtl/dcache_direct.sv - direct-mapped write-back write-allocate data cache
module dcache_direct #(
    parameter int NUM_LINES = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    input  logic         req_write,
    input  logic         req_byte,
    input  logic [31:0]  req_addr,
    input  logic [31:0]  req_wdata,
    output logic [31:0]  rdata,
    output logic         dhit,
    output logic         mem_req,
    output logic         mem_write,
    output logic [31:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 28 - IDX_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;
    state_t state;

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [31:0]          data_q [NUM_LINES][4];
    logic [27:0]          fill_line_q;

    logic [IDX_W-1:0] idx;
    logic [1:0]       word;
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic             hit;

    assign idx      = req_addr[4 +: IDX_W];
    assign word     = req_addr[3:2];
    assign tag      = req_addr[31 -: TAG_W];
    assign fill_idx = fill_line_q[IDX_W-1:0];
    assign fill_tag = fill_line_q[27 -: TAG_W];

    assign hit   = (state == IDLE) && req_valid && valid_q[idx] && (tag_q[idx] == tag);
    assign dhit  = (state == IDLE) ? (~req_valid | hit) : 1'b0;
    assign rdata = hit ? data_q[idx][word] : 32'h0;

    // The fill line is latched at miss detect so a dropped request cannot retarget the install.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            mem_req     <= 1'b0;
            mem_write   <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            fill_line_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (hit) begin
                            if (req_write) begin
                                dirty_q[idx] <= 1'b1;
                                if (req_byte)
                                    data_q[idx][word][{req_addr[1:0], 3'b000} +: 8] <= req_wdata[7:0];
                                else
                                    data_q[idx][word] <= req_wdata;
                            end
                        end else begin
                            fill_line_q <= req_addr[31:4];
                            mem_req     <= 1'b1;
                            if (valid_q[idx] && dirty_q[idx]) begin
                                state     <= WRITEBACK;
                                mem_write <= 1'b1;
                                mem_addr  <= {tag_q[idx], idx, 4'h0};
                                mem_wdata <= {data_q[idx][3], data_q[idx][2],
                                              data_q[idx][1], data_q[idx][0]};
                            end else begin
                                state     <= FILL;
                                mem_write <= 1'b0;
                                mem_addr  <= {req_addr[31:4], 4'h0};
                            end
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ready) begin
                        state     <= FILL;
                        mem_write <= 1'b0;
                        mem_addr  <= {fill_line_q, 4'h0};
                    end
                end
                FILL: begin
                    if (mem_ready) begin
                        state                <= IDLE;
                        mem_req              <= 1'b0;
                        valid_q[fill_idx]    <= 1'b1;
                        dirty_q[fill_idx]    <= 1'b0;
                        tag_q[fill_idx]      <= fill_tag;
                        data_q[fill_idx][0]  <= mem_rdata[31:0];
                        data_q[fill_idx][1]  <= mem_rdata[63:32];
                        data_q[fill_idx][2]  <= mem_rdata[95:64];
                        data_q[fill_idx][3]  <= mem_rdata[127:96];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_direct.sv
// tb/tb_dcache_direct.sv - self-checking bench for dcache_direct
module tb_dcache_direct;
    localparam int NL = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid, req_write, req_byte;
    logic [31:0]  req_addr, req_wdata;
    logic [31:0]  rdata;
    logic         dhit, mem_req, mem_write, mem_ready;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;

    dcache_direct #(.NUM_LINES(NL)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_byte(req_byte),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rdata(rdata), .dhit(dhit),
        .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // reference cache: line address per slot plus word contents
    bit           rv    [NL];
    bit           rd    [NL];
    logic [31:0]  rline [NL];
    logic [31:0]  rdat  [NL][4];
    logic [127:0] bmem  [logic [31:0]];

    int           wb_cnt = 0, fill_cnt = 0;
    logic [31:0]  last_wb_addr;
    logic [127:0] last_wb_data;
    logic [31:0]  last_rd;
    bit           last_miss;

    function automatic logic [127:0] line_of(int s);
        return {rdat[s][3], rdat[s][2], rdat[s][1], rdat[s][0]};
    endfunction

    task automatic mem_phase(input bit wr, input logic [31:0] a, input logic [127:0] wd, input int dly);
        @(negedge clk);
        n_cmp++;
        if (mem_req !== 1'b1 || mem_write !== wr || mem_addr !== a) begin
            n_err++;
            $display("FAIL mem_txn: req=%b write=%b addr=%h, required req=1 write=%b addr=%h",
                     mem_req, mem_write, mem_addr, wr, a);
        end
        if (wr) begin
            n_cmp++;
            if (mem_wdata !== wd) begin
                n_err++;
                $display("FAIL wb_data: got %h required %h", mem_wdata, wd);
            end
            wb_cnt++;
            last_wb_addr = mem_addr;
            last_wb_data = mem_wdata;
        end else begin
            fill_cnt++;
        end
        for (int i = 0; i < dly; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            n_cmp++;
            if (mem_req !== 1'b1 || dhit !== 1'b0 || mem_addr !== a) begin
                n_err++;
                $display("FAIL mem_hold: req=%b dhit=%b addr=%h, required 1 0 %h", mem_req, dhit, mem_addr, a);
            end
        end
        @(posedge clk); #1;
        mem_ready = 1'b1;
        if (!wr) mem_rdata = bmem[a];
        @(posedge clk); #1;
        mem_ready = 1'b0;
        mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic access(input bit w, input bit b, input logic [31:0] a, input logic [31:0] wd, input int dly);
        int          s;
        int          wi;
        logic [31:0] line;
        s    = int'((a >> 4) % NL);
        wi   = int'(a[3:2]);
        line = {a[31:4], 4'h0};
        req_valid = 1'b1; req_write = w; req_byte = b; req_addr = a; req_wdata = wd;
        @(negedge clk);
        last_miss = !(rv[s] && rline[s] == line);
        if (last_miss) begin
            n_cmp++;
            if (dhit !== 1'b0) begin
                n_err++;
                $display("FAIL miss_dhit: addr=%h dhit=%b required 0", a, dhit);
            end
            @(posedge clk); #1;
            if (rv[s] && rd[s]) begin
                mem_phase(1'b1, rline[s], line_of(s), dly);
                bmem[rline[s]] = line_of(s);
            end
            if (!bmem.exists(line)) bmem[line] = {$urandom, $urandom, $urandom, $urandom};
            mem_phase(1'b0, line, '0, dly);
            rv[s] = 1'b1; rd[s] = 1'b0; rline[s] = line;
            for (int k = 0; k < 4; k++) rdat[s][k] = bmem[line][32*k +: 32];
            @(negedge clk);
        end else begin
            n_cmp++;
            if (mem_req !== 1'b0) begin
                n_err++;
                $display("FAIL hit_memreq: addr=%h mem_req=%b required 0", a, mem_req);
            end
        end
        n_cmp++;
        if (dhit !== 1'b1) begin
            n_err++;
            $display("FAIL hit_dhit: addr=%h dhit=%b required 1", a, dhit);
        end
        last_rd = rdata;
        if (!w) begin
            n_cmp++;
            if (rdata !== rdat[s][wi]) begin
                n_err++;
                $display("FAIL load_data: addr=%h got %h required %h", a, rdata, rdat[s][wi]);
            end
        end else begin
            if (b) rdat[s][wi][8*a[1:0] +: 8] = wd[7:0];
            else   rdat[s][wi] = wd;
            rd[s] = 1'b1;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0;
        req_addr = '0; req_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++;
        if (dhit !== 1'b1 || mem_req !== 1'b0 || mem_write !== 1'b0 || mem_addr !== 32'h0
            || mem_wdata !== 128'h0 || rdata !== 32'h0) begin
            n_err++;
            $display("FAIL reset_state: dhit=%b req=%b wr=%b addr=%h wdata=%h rdata=%h",
                     dhit, mem_req, mem_write, mem_addr, mem_wdata, rdata);
        end
        req_valid = 1'b1; req_addr = 32'h40;
        #1;
        n_cmp++;
        if (dhit !== 1'b0) begin
            n_err++;
            $display("FAIL reset_dhit: dhit=%b required 0 with req_valid=1", dhit);
        end
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < NL; i++) begin rv[i] = 1'b0; rd[i] = 1'b0; end
    endtask

    task automatic test_cold_fill;
        int f0, w0;
        f0 = fill_cnt; w0 = wb_cnt;
        bmem[32'h100] = {32'h33, 32'h22, 32'h11, 32'h00};
        access(1'b0, 1'b0, 32'h100, 32'h0, 3);
        n_cmp++;
        if (!last_miss || fill_cnt != f0 + 1 || wb_cnt != w0 || last_rd !== 32'h0) begin
            n_err++;
            $display("FAIL cold_fill: miss=%b fills=%0d wbs=%0d rdata=%h required 1 1 0 00000000",
                     last_miss, fill_cnt - f0, wb_cnt - w0, last_rd);
        end
        access(1'b0, 1'b0, 32'h10C, 32'h0, 0);
        n_cmp++;
        if (last_miss || last_rd !== 32'h33) begin
            n_err++;
            $display("FAIL cold_hit: miss=%b rdata=%h required 0 00000033", last_miss, last_rd);
        end
    endtask

    task automatic test_byte_store;
        access(1'b1, 1'b1, 32'h101, 32'hFFFF_FFAB, 0);
        n_cmp++;
        if (last_miss) begin
            n_err++;
            $display("FAIL byte_store_hit: miss=%b required 0", last_miss);
        end
        access(1'b0, 1'b0, 32'h100, 32'h0, 0);
        n_cmp++;
        if (last_rd !== 32'h0000AB00) begin
            n_err++;
            $display("FAIL byte_store_load: got %h required 0000ab00", last_rd);
        end
    endtask

    task automatic test_dirty_conflict;
        int w0;
        w0 = wb_cnt;
        access(1'b0, 1'b0, 32'h180, 32'h0, 1);
        n_cmp++;
        if (wb_cnt != w0 + 1 || last_wb_addr !== 32'h100 || last_wb_data[31:0] !== 32'h0000AB00) begin
            n_err++;
            $display("FAIL dirty_conflict: wbs=%0d addr=%h word0=%h required 1 00000100 0000ab00",
                     wb_cnt - w0, last_wb_addr, last_wb_data[31:0]);
        end
    endtask

    task automatic test_store_miss;
        int w0, f0;
        w0 = wb_cnt; f0 = fill_cnt;
        access(1'b1, 1'b0, 32'h204, 32'hDEADBEEF, 2);
        n_cmp++;
        if (wb_cnt != w0 || fill_cnt != f0 + 1) begin
            n_err++;
            $display("FAIL store_miss_txn: wbs=%0d fills=%0d required 0 1", wb_cnt - w0, fill_cnt - f0);
        end
        access(1'b0, 1'b0, 32'h204, 32'h0, 0);
        n_cmp++;
        if (last_miss || last_rd !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL store_miss_load: miss=%b got %h required 0 deadbeef", last_miss, last_rd);
        end
        w0 = wb_cnt;
        access(1'b0, 1'b0, 32'h284, 32'h0, 1);
        n_cmp++;
        if (wb_cnt != w0 + 1 || last_wb_addr !== 32'h200 || last_wb_data[63:32] !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL store_miss_wb: wbs=%0d addr=%h word1=%h required 1 00000200 deadbeef",
                     wb_cnt - w0, last_wb_addr, last_wb_data[63:32]);
        end
    endtask

    task automatic test_idle_ready;
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mem_ready = i[0];
            @(negedge clk);
            n_cmp++;
            if (dhit !== 1'b1 || mem_req !== 1'b0) begin
                n_err++;
                $display("FAIL idle_ready: cycle %0d dhit=%b mem_req=%b required 1 0", i, dhit, mem_req);
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        access(1'b0, 1'b0, 32'h288, 32'h0, 0);
        n_cmp++;
        if (last_miss) begin
            n_err++;
            $display("FAIL idle_state: resident line missed after idle ready pulses");
        end
    endtask

    task automatic test_reset_mid_fill;
        int f0;
        req_valid = 1'b1; req_write = 1'b0; req_byte = 1'b0; req_addr = 32'h3C0;
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (mem_req !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 32'h3C0) begin
            n_err++;
            $display("FAIL rst_fill_start: req=%b wr=%b addr=%h required 1 0 000003c0", mem_req, mem_write, mem_addr);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL rst_fill_abort: mem_req=%b required 0", mem_req);
        end
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < NL; i++) begin rv[i] = 1'b0; rd[i] = 1'b0; end
        f0 = fill_cnt;
        access(1'b0, 1'b0, 32'h3C0, 32'h0, 1);
        n_cmp++;
        if (!last_miss || fill_cnt != f0 + 1) begin
            n_err++;
            $display("FAIL rst_fill_refetch: miss=%b fills=%0d required 1 1", last_miss, fill_cnt - f0);
        end
    endtask

    task automatic test_random;
        logic [31:0] a;
        bit          w, b;
        for (int n = 0; n < 200; n++) begin
            a = 32'h1000 | ($urandom_range(0, 3) << 7) | $urandom_range(0, 127);
            w = $urandom_range(0, 1) == 1;
            b = w && ($urandom_range(0, 2) == 0);
            access(w, b, a, $urandom, int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        test_reset;
        test_cold_fill;
        test_byte_store;
        test_dirty_conflict;
        test_store_miss;
        test_idle_ready;
        test_reset_mid_fill;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete within time limit");
        $fatal(1);
    end
endmodule
